irq_ctrl: RTL

//   Parametrised vectored interrupt controller for the LCR580 CPU. It replaces
//   the single fixed request line with NSRC prioritised sources, each with a
//   per-source mask, edge or level mode, pending latch and in-service latch.
//   It sits beside the io block on the CPU port bus and drives the CPU irq and

---
 rtl/irq_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl -- prioritised vectored interrupt controller for the LCR580 CPU.
//
// NSRC request lines are synchronised, latched as pending (edge or level
// mode), masked, arbitrated by fixed priority (index 0 highest) and presented
// to the CPU as a registered irq plus a 4-bit vector. Four registers sit at
// BASE_PORT+0..3 on the CPU port bus: MASK, MODE, PEND (W1C), ISR (write=EOI).
//
// Ports
//   clock    in   system clock
//   reset    in   asynchronous active-high reset
//   src      in   raw request lines (asynchronous to clock)
//   address  in   CPU port address
//   out      in   CPU write data
//   port_we  in   CPU port write strobe
//   port_rd  in   CPU port read strobe (reads have no side effects)
//   pin      out  register read data, 8'h00 when address is not mapped
//   sel      out  address falls inside the register window
//   iff1     in   CPU interrupt-enable flag
//   ack      in   CPU interrupt acknowledge pulse
//   irq      out  registered interrupt request
//   vect     out  registered vector of the current winner
module irq_ctrl #(
  parameter int          NSRC      = 8,
  parameter logic [3:0]  VBASE     = 4'h0,
  parameter logic [7:0]  BASE_PORT = 8'h20
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [7:0]      address,
  input  logic [7:0]      out,
  input  logic            port_we,
  input  logic            port_rd,
  output logic [7:0]      pin,
  output logic            sel,
  input  logic            iff1,
  input  logic            ack,
  output logic            irq,
  output logic [3:0]      vect
);

  logic [NSRC-1:0] s1_q, s2_q, s3_q;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] isr_q, isr_d;
  logic            irq_q, irq_d;
  logic [3:0]      vect_q, vect_d;

  logic [NSRC-1:0] edge_w, blk, cand, ack_vec;
  logic [7:0]      off, rd8;
  logic            wr_en, wr_mask, wr_mode, wr_pend, wr_isr, ack_take, found;
  logic [3:0]      win, ack_idx;
  logic            unused_rd;

  // Reads are side-effect free, so the read strobe carries no information.
  assign unused_rd = port_rd;

  function automatic logic [3:0] lowest_idx(input logic [NSRC-1:0] v);
    lowest_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

  // Offset arithmetic wraps, so the window may straddle address 8'hFF.
  assign off     = address - BASE_PORT;
  assign sel     = (off[7:2] == 6'd0);
  assign wr_en   = port_we & sel;
  assign wr_mask = wr_en & (off[1:0] == 2'd0);
  assign wr_mode = wr_en & (off[1:0] == 2'd1);
  assign wr_pend = wr_en & (off[1:0] == 2'd2);
  assign wr_isr  = wr_en & (off[1:0] == 2'd3);

  assign edge_w   = s2_q & ~s3_q;
  assign ack_take = ack & irq_q;
  assign ack_idx  = vect_q - VBASE;

  always_comb begin
    rd8 = '0;
    case (off[1:0])
      2'd0:    rd8[NSRC-1:0] = mask_q;
      2'd1:    rd8[NSRC-1:0] = mode_q;
      2'd2:    rd8[NSRC-1:0] = pend_q;
      default: rd8[NSRC-1:0] = isr_q;
    endcase
    pin = sel ? rd8 : 8'h00;
  end

  // blk[i] is set when any in-service bit at index <= i is set, so every
  // source at or below the priority of the active handler is held off.
  always_comb begin
    blk = '0;
    for (int i = 0; i < NSRC; i++) begin
      blk[i] = (i == 0) ? isr_q[0] : (blk[i-1] | isr_q[i]);
    end
  end

  assign cand = pend_q & mask_q & ~blk;
  assign win  = lowest_idx(cand);

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_vec[i] = ack_take && (ack_idx == 4'(i));
    end
  end

  always_comb begin
    mask_d = wr_mask ? out[NSRC-1:0] : mask_q;
    mode_d = wr_mode ? out[NSRC-1:0] : mode_q;
    pend_d = pend_q;
    for (int i = 0; i < NSRC; i++) begin
      if (mode_q[i]) begin
        // Level bits track the synchronised line; a switch to edge mode drops them.
        pend_d[i] = (wr_mode && !out[i]) ? 1'b0 : s2_q[i];
      end else begin
        // Clears first, then a fresh edge, so a new edge always survives.
        if (wr_pend && out[i]) pend_d[i] = 1'b0;
        if (ack_vec[i])        pend_d[i] = 1'b0;
        if (edge_w[i])         pend_d[i] = 1'b1;
      end
    end
  end

  // EOI retires the lowest in-service bit before any same-clock ack sets a new one.
  always_comb begin
    isr_d = isr_q;
    found = 1'b0;
    if (wr_isr) begin
      for (int i = 0; i < NSRC; i++) begin
        if (isr_q[i] && !found) begin
          isr_d[i] = 1'b0;
          found    = 1'b1;
        end
      end
    end
    isr_d = isr_d | ack_vec;
  end

  assign irq_d  = iff1 & (|cand) & ~ack;
  assign vect_d = (|cand) ? (VBASE + win) : vect_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      isr_q  <= '0;
      irq_q  <= 1'b0;
      vect_q <= 4'h0;
    end else begin
      s1_q   <= src;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      irq_q  <= irq_d;
      vect_q <= vect_d;
    end
  end

  assign irq  = irq_q;
  assign vect = vect_q;

endmodule
